// File: rtl/gf180_tiebank_pkg.sv
// Shared types for the programmable tie bank: load-state encoding and width limit.
package gf180_tiebank_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/gf180mcu_osu_sc_9t_tiebank_sreg.sv
// Shadow shift register with saturating bit counter and registered serial-out.
module gf180mcu_osu_sc_9t_tiebank_sreg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sdi_i,
  input  logic             shift_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] shadow_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             sdo_o
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sdo_q;

  if (WIDTH == 1) begin : g_one
    assign shifted = sdi_i;
  end else begin : g_many
    assign shifted = {sdi_i, shadow_q[WIDTH-1:1]};
  end

  assign full_o = (count_q == CNT_W'(WIDTH));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (shift_i && !full_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // sdo holds the bit most recently pushed out of shadow[0], so it only moves on a shift.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      count_q  <= '0;
      sdo_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (shift_i) begin
        shadow_q <= shifted;
        sdo_q    <= shadow_q[0];
      end
    end
  end

  assign shadow_o = shadow_q;
  assign count_o  = count_q;
  assign sdo_o    = sdo_q;

endmodule

// File: rtl/gf180mcu_osu_sc_9t_tiebank.sv
// Field-programmable tie-high/tie-low bank: serial load, commit handshake, held outputs.
// Optional commit lock enabled by defining GF180_TIEBANK_LOCK_EN (adds LOCK input).
module gf180mcu_osu_sc_9t_tiebank
  import gf180_tiebank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             SDI,
  input  logic             SEN,
  input  logic             SCOMMIT,
`ifdef GF180_TIEBANK_LOCK_EN
  input  logic             LOCK,
`endif
  output logic             SDO,
  output logic [WIDTH-1:0] Y,
  output logic             ACK,
  output logic             ERR,
  output state_t           dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q;
  logic             ack_q;
  logic             err_q, err_d;
  logic [WIDTH-1:0] shadow;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             locked;
  logic             shift_en;
  logic             commit_ok;
  logic             commit_bad;
  logic             overflow;

`ifdef GF180_TIEBANK_LOCK_EN
  logic locked_q;
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      locked_q <= 1'b0;
    end else if (commit_ok && LOCK) begin
      locked_q <= 1'b1;
    end
  end
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  // Any commit request, accepted or not, pre-empts a shift on the same edge.
  assign shift_en   = SEN & ~SCOMMIT;
  assign commit_ok  = SCOMMIT & (state_q == ST_FULL) & ~locked;
  assign commit_bad = SCOMMIT & ~commit_ok;
  assign overflow   = shift_en & full;

  gf180mcu_osu_sc_9t_tiebank_sreg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_sreg (
    .clk_i    (CLK),
    .rst_ni   (RN),
    .sdi_i    (SDI),
    .shift_i  (shift_en),
    .clear_i  (commit_ok),
    .shadow_o (shadow),
    .count_o  (count),
    .full_o   (full),
    .sdo_o    (SDO)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (commit_ok) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (shift_en) state_d = (WIDTH == 1) ? ST_FULL : ST_LOADING;
        end
        ST_LOADING: begin
          if (shift_en && (count == CNT_W'(WIDTH - 1))) state_d = ST_FULL;
        end
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_IDLE;
      endcase
    end
    if (commit_ok) begin
      err_d = 1'b0;
    end else if (commit_bad || overflow) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      y_q     <= RESET_VAL;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ack_q   <= commit_ok;
      if (commit_ok) y_q <= shadow;
    end
  end

  assign Y           = y_q;
  assign ACK         = ack_q;
  assign ERR         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_tiebank.sv
// Directed bench for the tie bank: reset, load/commit, short load, overflow, priority, lock.
module tb_gf180mcu_osu_sc_9t_tiebank;
  import gf180_tiebank_pkg::*;

  localparam int         W    = 8;
  localparam logic [7:0] RVAL = 8'hA5;

  logic         CLK = 1'b0;
  logic         RN;
  logic         SDI;
  logic         SEN;
  logic         SCOMMIT;
  logic         SDO;
  logic [W-1:0] Y;
  logic         ACK;
  logic         ERR;
  state_t       dbg_state;
`ifdef GF180_TIEBANK_LOCK_EN
  logic         LOCK;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  gf180mcu_osu_sc_9t_tiebank #(
    .WIDTH     (W),
    .RESET_VAL (RVAL)
  ) dut (
    .CLK         (CLK),
    .RN          (RN),
    .SDI         (SDI),
    .SEN         (SEN),
    .SCOMMIT     (SCOMMIT),
`ifdef GF180_TIEBANK_LOCK_EN
    .LOCK        (LOCK),
`endif
    .SDO         (SDO),
    .Y           (Y),
    .ACK         (ACK),
    .ERR         (ERR),
    .dbg_state_o (dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, take the edge, settle 1ns, return inputs to idle.
  task automatic cyc(input logic sen, input logic sdi, input logic scommit);
    SEN     = sen;
    SDI     = sdi;
    SCOMMIT = scommit;
    @(posedge CLK);
    #1;
    SEN     = 1'b0;
    SDI     = 1'b0;
    SCOMMIT = 1'b0;
  endtask

  task automatic shift_bits(input logic [15:0] v, input int from, input int n);
    logic [15:0] bits;
    bits = v;
    for (int i = from; i < from + n; i++) cyc(1'b1, bits[i], 1'b0);
  endtask

  task automatic async_reset();
    #3;
    RN = 1'b0;
    #1;
    check("rst_y",   Y,   RVAL);
    check("rst_ack", ACK, 1'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_sdo", SDO, 1'b0);
    check("rst_st",  dbg_state, ST_IDLE);
    @(posedge CLK);
    #1;
    RN = 1'b1;
  endtask

  initial begin
    RN      = 1'b1;
    SDI     = 1'b0;
    SEN     = 1'b0;
    SCOMMIT = 1'b0;
`ifdef GF180_TIEBANK_LOCK_EN
    LOCK    = 1'b0;
`endif
    @(posedge CLK);
    #1;
    async_reset();
    cyc(1'b0, 1'b0, 1'b0);

    // Normal load: 1,0,1,1,0,0,1,0 first-to-last lands as 8'h4D.
    shift_bits(16'h004D, 0, 8);
    check("load_st_full", dbg_state, ST_FULL);
    check("load_y_held",  Y,   RVAL);
    check("load_err",     ERR, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("commit_y",   Y,   8'h4D);
    check("commit_ack", ACK, 1'b1);
    check("commit_err", ERR, 1'b0);
    check("commit_st",  dbg_state, ST_IDLE);
    cyc(1'b0, 1'b0, 1'b0);
    check("ack_pulse",  ACK, 1'b0);
    check("y_stable",   Y,   8'h4D);

    // Short load: 5 of 8 bits then commit is rejected.
    shift_bits(16'h0096, 0, 5);
    check("short_st", dbg_state, ST_LOADING);
    cyc(1'b0, 1'b0, 1'b1);
    check("short_y",   Y,   8'h4D);
    check("short_err", ERR, 1'b1);
    check("short_ack", ACK, 1'b0);
    shift_bits(16'h0096, 5, 3);
    check("short_full", dbg_state, ST_FULL);
    cyc(1'b0, 1'b0, 1'b1);
    check("short2_y",   Y,   8'h96);
    check("short2_err", ERR, 1'b0);
    check("short2_ack", ACK, 1'b1);

    // Overflow: 9 bits (first 1, second 0); shadow keeps the last 8 = 8'hB4.
    shift_bits(16'h0169, 0, 8);
    check("ovf8_err", ERR, 1'b0);
    shift_bits(16'h0169, 8, 1);
    check("ovf_err", ERR, 1'b1);
    check("ovf_st",  dbg_state, ST_FULL);
    check("ovf_sdo", SDO, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    check("prio_y",   Y,   8'hB4);
    check("prio_ack", ACK, 1'b1);
    check("prio_err", ERR, 1'b0);
    check("prio_sdo", SDO, 1'b1);
    check("prio_st",  dbg_state, ST_IDLE);
    cyc(1'b1, 1'b1, 1'b0);
    check("cnt_clr_st", dbg_state, ST_LOADING);

    // Reset mid-load: partial bits must not count toward the next load.
    shift_bits(16'h0005, 0, 3);
    async_reset();
    shift_bits(16'h00FF, 0, 7);
    check("resid_st", dbg_state, ST_LOADING);
    shift_bits(16'h00FF, 7, 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("resid_y",   Y,   8'hFF);
    check("resid_ack", ACK, 1'b1);

`ifdef GF180_TIEBANK_LOCK_EN
    LOCK = 1'b1;
    shift_bits(16'h003C, 0, 8);
    cyc(1'b0, 1'b0, 1'b1);
    check("lock_y",   Y,   8'h3C);
    check("lock_ack", ACK, 1'b1);
    LOCK = 1'b0;
    shift_bits(16'h00C3, 0, 8);
    cyc(1'b0, 1'b0, 1'b1);
    check("locked_y",   Y,   8'h3C);
    check("locked_err", ERR, 1'b1);
    check("locked_ack", ACK, 1'b0);
    async_reset();
    shift_bits(16'h00C3, 0, 8);
    cyc(1'b0, 1'b0, 1'b1);
    check("unlock_y",   Y,   8'hC3);
    check("unlock_ack", ACK, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
